// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_pkg
// Brief    : Mode constants and the add/carry/clamp helper for acc_chan.
// Revision : 1.0
// ============================================================================
package acc_pkg;

    localparam int ACC_WRAP  = 0;
    localparam int ACC_SAT   = 1;
    // Widest accumulator the helper supports.
    localparam int ACC_MAX_W = 64;

    typedef struct packed {
        logic [ACC_MAX_W-1:0] sum;
        logic                 carry;
        logic [ACC_MAX_W-1:0] res;
    } acc_res_t;

    function automatic acc_res_t acc_add(
        input logic [ACC_MAX_W-1:0] a,
        input logic [ACC_MAX_W-1:0] b,
        input int unsigned          w,
        input logic                 sat
    );
        acc_res_t             r;
        logic [ACC_MAX_W-1:0] mask;
        logic [ACC_MAX_W:0]   full;
        mask    = (w >= ACC_MAX_W) ? '1 : ~({ACC_MAX_W{1'b1}} << w);
        full    = {1'b0, a & mask} + {1'b0, b & mask};
        // Both addends are below 2^w, so anything at or above bit w is the carry.
        r.carry = |(full >> w);
        r.sum   = full[ACC_MAX_W-1:0] & mask;
        r.res   = (sat && r.carry) ? mask : r.sum;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_lane.sv
`default_nettype none
// ============================================================================
// Module   : acc_lane
// Brief    : One accumulator channel: register, add/clamp, sticky overflow.
// Revision : 1.0
// ============================================================================
module acc_lane
    import acc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic             clr,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf
);

    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    acc_res_t         w_res;
    logic             w_nxt_ovf;
    logic             w_unused;

    always_comb begin
        w_res     = acc_add(ACC_MAX_W'(r_acc), ACC_MAX_W'(x), WIDTH, SATURATE == ACC_SAT);
        nxt       = clr ? x : w_res.res[WIDTH-1:0];
        w_nxt_ovf = clr ? 1'b0 : (r_ovf | w_res.carry);
    end

    assign w_unused = ^{w_res.sum, w_res.res};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (upd) begin
            r_acc <= nxt;
            r_ovf <= w_nxt_ovf;
        end
    end

    assign acc = r_acc;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/acc_chan.sv
`default_nettype none
// ============================================================================
// Module   : acc_chan
// Brief    : Multi-channel accumulator bank with wrap or saturate mode.
// Revision : 1.0
// ============================================================================
module acc_chan
    import acc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CW-1:0]       in_ch,
    input  logic [WIDTH-1:0]    in_x,
    input  logic                in_clr,
    input  logic [CW-1:0]       rd_ch,
    output logic [WIDTH-1:0]    q,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_q,
    output logic [CHANNELS-1:0] ovf
);

    logic [WIDTH-1:0]    w_acc [CHANNELS];
    logic [WIDTH-1:0]    w_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_upd;
    logic [WIDTH-1:0]    w_nxt_sel;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_q;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
            // Out-of-range channel indices never match, so they are dropped here.
            assign w_upd[g] = in_valid && (in_ch == CW'(g));

            acc_lane #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_lane (
                .clk (clk),
                .rst (rst),
                .upd (w_upd[g]),
                .clr (in_clr),
                .x   (in_x),
                .acc (w_acc[g]),
                .nxt (w_nxt[g]),
                .ovf (ovf[g])
            );
        end
    endgenerate

    always_comb begin
        q         = '0;
        w_nxt_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) q = w_acc[i];
            if (w_upd[i])        w_nxt_sel = w_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
        end else begin
            r_out_valid <= |w_upd;
            if (|w_upd) r_out_q <= w_nxt_sel;
        end
    end

    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_chan.sv
`default_nettype none
// Directed bench for acc_chan: one 32-bit wrap instance, 8-bit wrap and saturate instances.
module tb_acc_chan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_ch = '0;
    logic [31:0] in_x = '0;
    logic        in_clr = 1'b0;
    logic [2:0]  rd_ch = '0;

    logic [31:0] q32, oq32;
    logic        ov32;
    logic [3:0]  ovf32;
    logic [7:0]  q8w, oq8w, q8s, oq8s;
    logic        ov8w, ov8s;
    logic [3:0]  ovf8w, ovf8s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_chan #(.WIDTH(32), .CHANNELS(4), .SATURATE(0), .CW(3)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_x(in_x),
        .in_clr(in_clr), .rd_ch(rd_ch), .q(q32), .out_valid(ov32), .out_q(oq32), .ovf(ovf32));

    acc_chan #(.WIDTH(8), .CHANNELS(4), .SATURATE(0), .CW(3)) dut8w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_x(in_x[7:0]),
        .in_clr(in_clr), .rd_ch(rd_ch), .q(q8w), .out_valid(ov8w), .out_q(oq8w), .ovf(ovf8w));

    acc_chan #(.WIDTH(8), .CHANNELS(4), .SATURATE(1), .CW(3)) dut8s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_x(in_x[7:0]),
        .in_clr(in_clr), .rd_ch(rd_ch), .q(q8s), .out_valid(ov8s), .out_q(oq8s), .ovf(ovf8s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_clr   = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
    endtask

    task automatic upd(input logic [2:0] ch, input logic [31:0] x, input logic clr);
        in_valid = 1'b1;
        in_ch    = ch;
        in_x     = x;
        in_clr   = clr;
        tick();
        in_valid = 1'b0;
        in_clr   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ov32, ov8w, ov8s} !== 3'b000) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 000", {ov32, ov8w, ov8s});
        end
        checks++;
        if (oq32 !== 32'd0 || oq8w !== 8'd0 || oq8s !== 8'd0) begin
            errors++; $display("FAIL reset_out_q: got %0d/%0d/%0d expected 0", oq32, oq8w, oq8s);
        end
        checks++;
        if ({ovf32, ovf8w, ovf8s} !== 12'h000) begin
            errors++; $display("FAIL reset_ovf: got %h expected 000", {ovf32, ovf8w, ovf8s});
        end
        for (int c = 0; c < 4; c++) begin
            rd_ch = 3'(c);
            #1;
            checks++;
            if (q32 !== 32'd0) begin
                errors++; $display("FAIL reset_q ch%0d: got %0d expected 0", c, q32);
            end
        end
    endtask

    task automatic test_long_sum();
        do_reset();
        rd_ch = 3'd0;
        for (int i = 0; i <= 1337; i++) begin
            in_valid = 1'b1; in_ch = 3'd0; in_x = 32'(i); in_clr = 1'b0;
            if (i == 1337) begin
                #1;
                checks++;
                if (q32 !== 32'd893116) begin
                    errors++; $display("FAIL old_q_in_update_cycle: got %0d expected 893116", q32);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (ov32 !== 1'b1 || oq32 !== 32'd894453) begin
            errors++; $display("FAIL long_sum_out: got v=%b q=%0d expected v=1 q=894453", ov32, oq32);
        end
        checks++;
        if (q32 !== 32'd894453) begin
            errors++; $display("FAIL long_sum_q: got %0d expected 894453", q32);
        end
        checks++;
        if (ovf32[0] !== 1'b0) begin
            errors++; $display("FAIL long_sum_ovf: got %b expected 0", ovf32[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        upd(3'd1, 32'd200, 1'b0);
        checks++;
        if (ov8w !== 1'b1 || oq8w !== 8'd200) begin
            errors++; $display("FAIL wrap_first: got v=%b q=%0d expected v=1 q=200", ov8w, oq8w);
        end
        upd(3'd1, 32'd100, 1'b0);
        checks++;
        if (oq8w !== 8'd44 || ovf8w !== 4'b0010) begin
            errors++; $display("FAIL wrap_second: got q=%0d ovf=%b expected q=44 ovf=0010", oq8w, ovf8w);
        end
        rd_ch = 3'd1;
        #1;
        checks++;
        if (q32 !== 32'd300 || ovf32 !== 4'b0000) begin
            errors++; $display("FAIL wrap_32bit: got q=%0d ovf=%b expected q=300 ovf=0000", q32, ovf32);
        end
        upd(3'd1, 32'd1, 1'b0);
        checks++;
        if (oq8w !== 8'd45 || ovf8w[1] !== 1'b1) begin
            errors++; $display("FAIL wrap_sticky: got q=%0d ovf1=%b expected q=45 ovf1=1", oq8w, ovf8w[1]);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_q [5];
        logic [31:0] xs [5];
        do_reset();
        xs[0] = 32'd200; xs[1] = 32'd100; xs[2] = 32'd5; xs[3] = 32'd0;
        exp_q[0] = 8'd200; exp_q[1] = 8'd255; exp_q[2] = 8'd255; exp_q[3] = 8'd255;
        for (int i = 0; i < 4; i++) begin
            upd(3'd2, xs[i], 1'b0);
            checks++;
            if (ov8s !== 1'b1 || oq8s !== exp_q[i]) begin
                errors++; $display("FAIL sat_step%0d: got v=%b q=%0d expected v=1 q=%0d", i, ov8s, oq8s, exp_q[i]);
            end
        end
        checks++;
        if (ovf8s !== 4'b0100) begin
            errors++; $display("FAIL sat_ovf: got %b expected 0100", ovf8s);
        end
        upd(3'd2, 32'd7, 1'b1);
        checks++;
        if (oq8s !== 8'd7 || ovf8s !== 4'b0000) begin
            errors++; $display("FAIL sat_clear: got q=%0d ovf=%b expected q=7 ovf=0000", oq8s, ovf8s);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  chs [3];
        logic [31:0] xs [3];
        logic [31:0] exp_o [3];
        logic [31:0] exp_q [4];
        do_reset();
        chs[0] = 3'd0; chs[1] = 3'd3; chs[2] = 3'd0;
        xs[0] = 32'd1; xs[1] = 32'd10; xs[2] = 32'd1;
        exp_o[0] = 32'd1; exp_o[1] = 32'd10; exp_o[2] = 32'd2;
        in_valid = 1'b1; in_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_ch = chs[i]; in_x = xs[i];
            tick();
            checks++;
            if (ov32 !== 1'b1 || oq32 !== exp_o[i]) begin
                errors++; $display("FAIL b2b_step%0d: got v=%b q=%0d expected v=1 q=%0d", i, ov32, oq32, exp_o[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got v=%b expected 0", ov32);
        end
        exp_q[0] = 32'd2; exp_q[1] = 32'd0; exp_q[2] = 32'd0; exp_q[3] = 32'd10;
        for (int c = 0; c < 4; c++) begin
            rd_ch = 3'(c);
            #1;
            checks++;
            if (q32 !== exp_q[c]) begin
                errors++; $display("FAIL b2b_q ch%0d: got %0d expected %0d", c, q32, exp_q[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        upd(3'd1, 32'd50, 1'b0);
        in_valid = 1'b1; in_ch = 3'd1; in_x = 32'd5; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (ov32 !== 1'b0 || ovf32 !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_out: got v=%b ovf=%b expected v=0 ovf=0000", ov32, ovf32);
        end
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_next: got v=%b expected 0", ov32);
        end
        rd_ch = 3'd1;
        #1;
        checks++;
        if (q32 !== 32'd0) begin
            errors++; $display("FAIL rst_mid_q: got %0d expected 0", q32);
        end
        // Update in the very cycle reset drops.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        upd(3'd1, 32'd9, 1'b0);
        checks++;
        if (ov32 !== 1'b1 || oq32 !== 32'd9 || q32 !== 32'd9) begin
            errors++; $display("FAIL rst_release_upd: got v=%b oq=%0d q=%0d expected v=1 9 9", ov32, oq32, q32);
        end
    endtask

    task automatic test_out_of_range();
        rd_ch = 3'd7;
        in_valid = 1'b1; in_ch = 3'd5; in_x = 32'd123; in_clr = 1'b0;
        #1;
        checks++;
        if (q32 !== 32'd0) begin
            errors++; $display("FAIL oor_q: got %0d expected 0", q32);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (ov32 !== 1'b0) begin
            errors++; $display("FAIL oor_out_valid: got %b expected 0", ov32);
        end
        in_ch = 3'd1; in_clr = 1'b1; in_x = 32'd77;
        tick();
        in_clr = 1'b0;
        checks++;
        if (ov32 !== 1'b0) begin
            errors++; $display("FAIL idle_clr_out_valid: got %b expected 0", ov32);
        end
        for (int c = 0; c < 4; c++) begin
            rd_ch = 3'(c);
            #1;
            checks++;
            if (q32 !== ((c == 1) ? 32'd9 : 32'd0)) begin
                errors++; $display("FAIL oor_hold ch%0d: got %0d expected %0d", c, q32, (c == 1) ? 9 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_long_sum();
        test_wrap();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
